// File: rtl/eth_frame_gen.sv
// GMII Ethernet frame generator: preamble/SFD, 14-byte header, streamed payload, zero pad,
// CRC-32 FCS and inter-frame gap. Define ETH_GEN_ERR_INJ_EN to add err_inj (corrupts FCS byte 0).
module eth_frame_gen #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_CYCLES   = 12,
  parameter int LEN_W        = 11,
  parameter int MIN_PAYLOAD  = 46,
  parameter int MAX_PAYLOAD  = 1500
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic [47:0]      cfg_dst_mac,
  input  logic [47:0]      cfg_src_mac,
  input  logic [15:0]      cfg_ethertype,
  input  logic [LEN_W-1:0] cfg_len,
`ifdef ETH_GEN_ERR_INJ_EN
  input  logic             err_inj,
`endif
  input  logic [7:0]       pl_data,
  input  logic             pl_valid,
  output logic             pl_ready,
  output logic [7:0]       gmii_txd,
  output logic             gmii_tx_en,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_PAD, S_FCS, S_IFG} state_t;

  localparam logic [LEN_W-1:0] PRE_LAST = LEN_W'(PREAMBLE_LEN - 1);
  localparam logic [LEN_W-1:0] HDR_LAST = LEN_W'(13);
  localparam logic [LEN_W-1:0] FCS_LAST = LEN_W'(3);
  localparam logic [LEN_W-1:0] IFG_LAST = LEN_W'(IFG_CYCLES - 1);
  localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(MIN_PAYLOAD);
  localparam logic [LEN_W-1:0] MIN_LAST = LEN_W'(MIN_PAYLOAD - 1);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_PAYLOAD);

  // state/cnt describe the byte currently on gmii_txd; nstate/ncnt the one loaded next edge
  state_t           state, nstate;
  logic [LEN_W-1:0] cnt, ncnt, cnt_inc, len_q;
  logic [111:0]     hdr_q;
  logic [31:0]      crc;
  logic [7:0]       nbyte;
  logic             fcs_flip, accept;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

`ifdef ETH_GEN_ERR_INJ_EN
  logic err_q;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst)     err_q <= 1'b0;
    else if (accept) err_q <= err_inj;
  assign fcs_flip = err_q;
`else
  assign fcs_flip = 1'b0;
`endif

  assign accept   = (state == S_IDLE) && start;
  assign cnt_inc  = cnt + LEN_W'(1);
  assign pl_ready = (nstate == S_PAY);

  always_comb begin
    nstate = state;
    ncnt   = cnt_inc;
    case (state)
      S_IDLE: begin
        ncnt = '0;
        if (start) nstate = S_PRE;
      end
      S_PRE: if (cnt == PRE_LAST) begin nstate = S_SFD; ncnt = '0; end
      S_SFD: begin nstate = S_HDR; ncnt = '0; end
      S_HDR: if (cnt == HDR_LAST) begin
        ncnt   = '0;
        nstate = (len_q == '0) ? S_PAD : S_PAY;
      end
      // pad continues the payload index so it ends at MIN_PAYLOAD-1 regardless of len
      S_PAY: if (cnt_inc == len_q) begin
        if (len_q < MIN_LEN) nstate = S_PAD;
        else begin nstate = S_FCS; ncnt = '0; end
      end
      S_PAD: if (cnt == MIN_LAST) begin nstate = S_FCS; ncnt = '0; end
      S_FCS: if (cnt == FCS_LAST) begin nstate = S_IFG; ncnt = '0; end
      S_IFG: if (cnt == IFG_LAST) begin nstate = S_IDLE; ncnt = '0; end
      default: begin nstate = S_IDLE; ncnt = '0; end
    endcase
  end

  always_comb begin
    nbyte = 8'h00;
    case (nstate)
      S_PRE: nbyte = 8'h55;
      S_SFD: nbyte = 8'hD5;
      S_HDR: nbyte = hdr_q[111:104];
      S_PAY: nbyte = pl_valid ? pl_data : 8'h00;
      S_FCS: begin
        case (ncnt[1:0])
          2'd0:    nbyte = ~crc[7:0] ^ {8{fcs_flip}};
          2'd1:    nbyte = ~crc[15:8];
          2'd2:    nbyte = ~crc[23:16];
          default: nbyte = ~crc[31:24];
        endcase
      end
      default: nbyte = 8'h00;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      len_q      <= '0;
      hdr_q      <= '0;
      crc        <= 32'hFFFF_FFFF;
      gmii_txd   <= 8'h00;
      gmii_tx_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= nstate;
      cnt        <= ncnt;
      gmii_txd   <= nbyte;
      gmii_tx_en <= nstate inside {S_PRE, S_SFD, S_HDR, S_PAY, S_PAD, S_FCS};
      busy       <= (nstate != S_IDLE);
      done       <= (nstate == S_IFG) && (ncnt == IFG_LAST);
      if (accept) begin
        len_q    <= (cfg_len > MAX_LEN) ? MAX_LEN : cfg_len;
        hdr_q    <= {cfg_dst_mac, cfg_src_mac, cfg_ethertype};
        crc      <= 32'hFFFF_FFFF;
        underrun <= 1'b0;
      end else begin
        if (nstate inside {S_HDR, S_PAY, S_PAD}) crc <= crc_byte(crc, nbyte);
        if (nstate == S_HDR) hdr_q <= {hdr_q[103:0], 8'h00};
        if (nstate == S_PAY && !pl_valid) underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eth_frame_gen.sv
// Directed bench for eth_frame_gen: vector table of frames plus reset, back-to-back and abort sequences.
module tb_eth_frame_gen;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        start = 1'b0;
  logic [47:0] cfg_dst_mac = '0;
  logic [47:0] cfg_src_mac = '0;
  logic [15:0] cfg_ethertype = '0;
  logic [10:0] cfg_len = '0;
  logic [7:0]  pl_data = '0;
  logic        pl_valid = 1'b0;
  logic        pl_ready, gmii_tx_en, busy, done, underrun;
  logic [7:0]  gmii_txd;
`ifdef ETH_GEN_ERR_INJ_EN
  logic        err_inj = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #4 sys_clk = ~sys_clk;

  eth_frame_gen dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
    .cfg_dst_mac(cfg_dst_mac), .cfg_src_mac(cfg_src_mac),
    .cfg_ethertype(cfg_ethertype), .cfg_len(cfg_len),
`ifdef ETH_GEN_ERR_INJ_EN
    .err_inj(err_inj),
`endif
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
    .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .busy(busy),
    .done(done), .underrun(underrun)
  );

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] etype;
    int          len;
    int          stall;      // payload slot driven with pl_valid=0, -1 for none
    bit          err;
    int          exp_txen;   // hand-computed tx_en cycles
    int          exp_ready;  // hand-computed pl_ready pulses
    bit          exp_under;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [7:0] pbyte(input int i);
    return 8'((i * 13 + 5) % 256);
  endfunction

  // bit-serial reflected CRC-32, no final inversion
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int b = 0; b < 8; b++)
      if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    return r;
  endfunction

  task automatic send(input vec_t v);
    logic [7:0]   got[$];
    logic [7:0]   exp[$];
    logic [111:0] h;
    logic [31:0]  res;
    int pidx, nready, cyc, bad, first_bad, ifg, ndone, done_pos, plen, n;
    bit take;
    cyc = 0;
    while (busy && cyc < 100) begin tick(); cyc++; end
    cfg_dst_mac   = v.dst;
    cfg_src_mac   = v.src;
    cfg_ethertype = v.etype;
    cfg_len       = 11'(v.len);
`ifdef ETH_GEN_ERR_INJ_EN
    err_inj = v.err;
`endif
    pl_valid = 1'b1;
    start    = 1'b1;
    tick();
    start = 1'b0;
    chk("start_txd", 32'(gmii_txd), 32'h55);
    chk("start_txen", 32'(gmii_tx_en), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_underrun_clr", 32'(underrun), 32'd0);
    // config changes after acceptance must not reach the frame
    cfg_dst_mac   = ~v.dst;
    cfg_src_mac   = ~v.src;
    cfg_ethertype = ~v.etype;
    cfg_len       = 11'd3;
`ifdef ETH_GEN_ERR_INJ_EN
    err_inj = ~v.err;
`endif
    pidx = 0; nready = 0; cyc = 0;
    while (gmii_tx_en && cyc < 3000) begin
      got.push_back(gmii_txd);
      pl_data  = pbyte(pidx);
      pl_valid = (pidx != v.stall);
      take     = pl_ready;
      tick();
      cyc++;
      if (take) begin pidx++; nready++; end
    end
    pl_valid = 1'b1;
    chk("txen_cycles", 32'(got.size()), 32'(v.exp_txen));
    chk("ready_pulses", 32'(nready), 32'(v.exp_ready));

    for (int i = 0; i < 7; i++) exp.push_back(8'h55);
    exp.push_back(8'hD5);
    h = {v.dst, v.src, v.etype};
    for (int i = 0; i < 14; i++) begin exp.push_back(h[111:104]); h = h << 8; end
    plen = (v.exp_ready > 46) ? v.exp_ready : 46;
    for (int i = 0; i < plen; i++)
      exp.push_back((i < v.exp_ready && i != v.stall) ? pbyte(i) : 8'h00);
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    bad = 0; first_bad = -1;
    for (int i = 0; i < n; i++)
      if (got[i] !== exp[i]) begin
        bad++;
        if (first_bad < 0) first_bad = i;
      end
    if (bad != 0)
      $display("  first byte diff at %0d: got %h exp %h", first_bad, got[first_bad], exp[first_bad]);
    chk("frame_bytes_bad", 32'(bad), 32'd0);

    res = 32'hFFFF_FFFF;
    for (int i = 8; i < got.size(); i++) res = crc_upd(res, got[i]);
    if (v.err) begin
      n_checks++;
      if (res == 32'hDEBB_20E3) begin
        n_fail++;
        $display("FAIL fcs_err_inj: got residue %h, required anything but DEBB20E3", res);
      end
    end else chk("fcs_residue", res, 32'hDEBB_20E3);

    ifg = 0; ndone = 0; done_pos = -1;
    while (busy && ifg < 100) begin
      if (done) begin ndone++; done_pos = ifg; end
      ifg++;
      tick();
    end
    chk("ifg_busy_cycles", 32'(ifg), 32'd12);
    chk("done_count", 32'(ndone), 32'd1);
    chk("done_position", 32'(done_pos), 32'd11);
    chk("underrun_after", 32'(underrun), 32'(v.exp_under));
  endtask

  initial begin
    int bad, rises, ndone, run, gaps, badgap, cyc;
    logic prev;

    vq.push_back('{48'h665544332211, 48'h6c1ff709fa24, 16'h0806, 46,   -1, 1'b0, 72,   46,   1'b0});
    vq.push_back('{48'h020000000001, 48'h0a0b0c0d0e0f, 16'h0800, 10,   -1, 1'b0, 72,   10,   1'b0});
    vq.push_back('{48'hffffffffffff, 48'h001122334455, 16'h88b5, 0,    -1, 1'b0, 72,   0,    1'b0});
    vq.push_back('{48'h123456789abc, 48'hcba987654321, 16'h86dd, 47,   -1, 1'b0, 73,   47,   1'b0});
    vq.push_back('{48'h665544332211, 48'h6c1ff709fa24, 16'h0800, 20,   4,  1'b0, 72,   20,   1'b1});
    vq.push_back('{48'h0180c2000001, 48'h00aabbccddee, 16'h0800, 2000, -1, 1'b0, 1526, 1500, 1'b0});
    vq.push_back('{48'h0000000000ff, 48'h000000000001, 16'h0600, 1500, -1, 1'b0, 1526, 1500, 1'b0});
`ifdef ETH_GEN_ERR_INJ_EN
    vq.push_back('{48'h665544332211, 48'h6c1ff709fa24, 16'h0806, 46,   -1, 1'b1, 72,   46,   1'b0});
`endif

    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_txd", 32'(gmii_txd), 32'd0);
    chk("rst_txen", 32'(gmii_tx_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_pl_ready", 32'(pl_ready), 32'd0);
    @(negedge sys_clk) sys_rst = 1'b0;

    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (gmii_tx_en || busy || done || gmii_txd != 8'h00 || pl_ready) bad++;
    end
    chk("idle_1000_bad", 32'(bad), 32'd0);

    foreach (vq[i]) send(vq[i]);

    // start held high: frames back to back with a 13-cycle tx_en gap
    cfg_len = 11'd0; pl_valid = 1'b1; start = 1'b1;
    rises = 0; ndone = 0; run = 0; gaps = 0; badgap = 0; prev = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (gmii_tx_en && !prev) begin
        rises++;
        if (rises > 1) begin
          gaps++;
          if (run != 13) badgap++;
        end
      end
      if (gmii_tx_en) run = 0; else run++;
      if (done) ndone++;
      prev = gmii_tx_en;
    end
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin
      tick(); cyc++;
      if (done) ndone++;
    end
    chk("b2b_frames", 32'(rises), 32'd5);
    chk("b2b_bad_gaps", 32'(badgap), 32'd0);
    chk("b2b_done_per_frame", 32'(ndone), 32'(rises));
    chk("b2b_idle_after", 32'(busy), 32'd0);

    // abort mid-payload with an asynchronous reset
    cfg_dst_mac = 48'h111111111111; cfg_len = 11'd100; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    chk("abort_pre_txen", 32'(gmii_tx_en), 32'd1);
    sys_rst = 1'b1;
    #1;
    chk("abort_txen_async", 32'(gmii_tx_en), 32'd0);
    chk("abort_busy_async", 32'(busy), 32'd0);
    chk("abort_txd_async", 32'(gmii_txd), 32'd0);
    @(negedge sys_clk);
    @(negedge sys_clk) sys_rst = 1'b0;
    tick();
    send(vq[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
